apb_arb_master: RTL and testbench

Two-port APB master that arbitrates between two local requesters and sequences the shared APB bus through IDLE/SETUP/ACCESS. It drives the address decoder/mux in front of the APB slaves and returns read data and error status to whichever requester owns the transfer. A per-transfer PREADY timeout keeps a hung slave from locking the bus.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_rr_arbiter.sv | 20 ++
 rtl/apb_arb_master.sv | 136 +++++++++++++
 tb/tb_apb_arb_master.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the two-port APB master.
//   APB_ADDR_W / APB_DATA_W : default address / data widths
//   apb_state_e             : bus sequencer state encoding
package apb_pkg;
  localparam int APB_ADDR_W = 10;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;
endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: 2-way round-robin arbiter.
//   req[1:0]    : request vector
//   last_grant  : index of the requester granted most recently
//   enable      : grant only while the bus is free
//   grant[1:0]  : one-hot grant (zero when disabled or no request)
module apb_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      // On a tie the requester not served last goes first.
      if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end
endmodule

// File: rtl/apb_arb_master.sv
// apb_arb_master: arbitrates two local requesters onto one APB bus.
//   PCLK/PRESET          : clock, synchronous active-high reset
//   REQ_*_n              : requester n transfer (valid/ready handshake)
//   RSP_*_n              : one-cycle completion pulse with read data / error
//   PSEL..PWDATA         : APB master outputs
//   PRDATA/PREADY/PSLVERR: APB slave returns
// A wait counter aborts ACCESS after TIMEOUT cycles of PREADY low (0 = off).
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  REQ_VALID_0,
  output logic                  REQ_READY_0,
  input  logic                  REQ_WRITE_0,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_0,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA_0,
  output logic                  RSP_VALID_0,
  output logic [DATA_WIDTH-1:0] RSP_RDATA_0,
  output logic                  RSP_ERR_0,
  input  logic                  REQ_VALID_1,
  output logic                  REQ_READY_1,
  input  logic                  REQ_WRITE_1,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_1,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA_1,
  output logic                  RSP_VALID_1,
  output logic [DATA_WIDTH-1:0] RSP_RDATA_1,
  output logic                  RSP_ERR_1,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  // Keep at least one bit so TIMEOUT=0 still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e                     r_state, w_state_nxt;
  logic                           r_last;
  logic                           r_owner;
  logic [CNT_W-1:0]               r_cnt;
  logic [ADDR_WIDTH-1:0]          r_paddr;
  logic                           r_pwrite;
  logic [DATA_WIDTH-1:0]          r_pwdata;
  logic [1:0]                     r_rsp_vld;
  logic [1:0]                     r_rsp_err;
  logic [1:0][DATA_WIDTH-1:0]     r_rsp_rdata;

  logic [1:0] w_grant;
  logic       w_accept, w_done, w_tmo;

  apb_rr_arbiter u_arb (
    .req        ({REQ_VALID_1, REQ_VALID_0}),
    .last_grant (r_last),
    .enable     (r_state == IDLE),
    .grant      (w_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: if (|w_grant) begin
        w_accept    = 1'b1;
        w_state_nxt = SETUP;
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: begin
        // PREADY in the last allowed cycle still counts as a completion.
        if (PREADY) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (TIMEOUT != 0 && r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_cnt       <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_vld   <= '0;
      r_rsp_err   <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rsp_vld <= '0;
      if (w_accept) begin
        r_paddr  <= w_grant[1] ? REQ_ADDR_1  : REQ_ADDR_0;
        r_pwrite <= w_grant[1] ? REQ_WRITE_1 : REQ_WRITE_0;
        r_pwdata <= w_grant[1] ? REQ_WDATA_1 : REQ_WDATA_0;
        r_owner  <= w_grant[1];
        r_last   <= w_grant[1];
      end
      if (r_state == SETUP)                 r_cnt <= '0;
      else if (r_state == ACCESS && !PREADY) r_cnt <= r_cnt + 1'b1;
      if (w_done || w_tmo) begin
        r_rsp_vld[r_owner]   <= 1'b1;
        r_rsp_err[r_owner]   <= w_tmo | PSLVERR;
        r_rsp_rdata[r_owner] <= (w_done && !r_pwrite) ? PRDATA : '0;
      end
    end
  end

  assign REQ_READY_0 = w_grant[0];
  assign REQ_READY_1 = w_grant[1];
  assign PSEL        = (r_state != IDLE);
  assign PENABLE     = (r_state == ACCESS);
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign RSP_VALID_0 = r_rsp_vld[0];
  assign RSP_VALID_1 = r_rsp_vld[1];
  assign RSP_ERR_0   = r_rsp_err[0];
  assign RSP_ERR_1   = r_rsp_err[1];
  assign RSP_RDATA_0 = r_rsp_rdata[0];
  assign RSP_RDATA_1 = r_rsp_rdata[1];
endmodule

// File: tb/tb_apb_arb_master.sv
module tb_apb_arb_master;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK, PRESET;
  logic          REQ_VALID_0, REQ_READY_0, REQ_WRITE_0, RSP_VALID_0, RSP_ERR_0;
  logic [AW-1:0] REQ_ADDR_0;
  logic [DW-1:0] REQ_WDATA_0, RSP_RDATA_0;
  logic          REQ_VALID_1, REQ_READY_1, REQ_WRITE_1, RSP_VALID_1, RSP_ERR_1;
  logic [AW-1:0] REQ_ADDR_1;
  logic [DW-1:0] REQ_WDATA_1, RSP_RDATA_1;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_arb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ_VALID_0(REQ_VALID_0), .REQ_READY_0(REQ_READY_0), .REQ_WRITE_0(REQ_WRITE_0),
    .REQ_ADDR_0(REQ_ADDR_0), .REQ_WDATA_0(REQ_WDATA_0),
    .RSP_VALID_0(RSP_VALID_0), .RSP_RDATA_0(RSP_RDATA_0), .RSP_ERR_0(RSP_ERR_0),
    .REQ_VALID_1(REQ_VALID_1), .REQ_READY_1(REQ_READY_1), .REQ_WRITE_1(REQ_WRITE_1),
    .REQ_ADDR_1(REQ_ADDR_1), .REQ_WDATA_1(REQ_WDATA_1),
    .RSP_VALID_1(RSP_VALID_1), .RSP_RDATA_1(RSP_RDATA_1), .RSP_ERR_1(RSP_ERR_1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: round-robin memory plus the one response due next cycle.
  bit            m_last;
  int            pend;
  logic [DW-1:0] pend_rdata;
  logic          pend_err;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset;
    PRESET = 1'b1;
    REQ_VALID_0 = 0; REQ_VALID_1 = 0; REQ_WRITE_0 = 0; REQ_WRITE_1 = 0;
    REQ_ADDR_0 = '0; REQ_ADDR_1 = '0; REQ_WDATA_0 = '0; REQ_WDATA_1 = '0;
    PRDATA = '0; PREADY = 0; PSLVERR = 0;
    repeat (3) tick;
    #1;
    n_vec++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin n_err++; $display("FAIL reset_ctl: got %b want 000", {PSEL, PENABLE, PWRITE}); end
    n_vec++; if (PADDR !== '0 || PWDATA !== '0) begin n_err++; $display("FAIL reset_bus: got %h/%h want 0/0", PADDR, PWDATA); end
    n_vec++; if ({RSP_VALID_0, RSP_VALID_1, RSP_ERR_0, RSP_ERR_1} !== 4'b0) begin n_err++; $display("FAIL reset_rsp: got %b want 0000", {RSP_VALID_0, RSP_VALID_1, RSP_ERR_0, RSP_ERR_1}); end
    n_vec++; if (RSP_RDATA_0 !== '0 || RSP_RDATA_1 !== '0) begin n_err++; $display("FAIL reset_rdata: got %h/%h want 0/0", RSP_RDATA_0, RSP_RDATA_1); end
    PRESET = 1'b0;
    tick;
    m_last = 1'b1;
    pend = -1;
  endtask

  // One complete transfer. Entered in an IDLE cycle (which may also carry the
  // previous response); returns in the cycle carrying this transfer's response.
  // w = number of PREADY-low ACCESS cycles before PREADY is raised.
  task automatic xfer(input logic [1:0] mask, input logic [1:0] wr,
                      input logic [1:0][AW-1:0] a, input logic [1:0][DW-1:0] d,
                      input int w, input logic serr, input logic [DW-1:0] rd);
    int            win, acc;
    bit            tmo;
    logic [DW-1:0] got;
    REQ_VALID_0 = mask[0]; REQ_WRITE_0 = wr[0]; REQ_ADDR_0 = a[0]; REQ_WDATA_0 = d[0];
    REQ_VALID_1 = mask[1]; REQ_WRITE_1 = wr[1]; REQ_ADDR_1 = a[1]; REQ_WDATA_1 = d[1];
    PREADY = 0; PSLVERR = 0; PRDATA = $urandom;
    #1;
    if (pend >= 0) begin
      got = (pend == 1) ? RSP_RDATA_1 : RSP_RDATA_0;
      n_vec++; if ({RSP_VALID_1, RSP_VALID_0} !== (2'b01 << pend)) begin n_err++; $display("FAIL rsp_valid: got %b want %b", {RSP_VALID_1, RSP_VALID_0}, 2'b01 << pend); end
      n_vec++; if (got !== pend_rdata) begin n_err++; $display("FAIL rsp_rdata port%0d: got %h want %h", pend, got, pend_rdata); end
      n_vec++; if (((pend == 1) ? RSP_ERR_1 : RSP_ERR_0) !== pend_err) begin n_err++; $display("FAIL rsp_err port%0d: want %b", pend, pend_err); end
    end else begin
      n_vec++; if ({RSP_VALID_1, RSP_VALID_0} !== 2'b00) begin n_err++; $display("FAIL rsp_spurious: got %b want 00", {RSP_VALID_1, RSP_VALID_0}); end
    end
    pend = -1;
    win = (mask == 2'b11) ? (m_last ? 0 : 1) : (mask[0] ? 0 : 1);
    n_vec++; if ({REQ_READY_1, REQ_READY_0} !== (2'b01 << win)) begin n_err++; $display("FAIL grant: got %b want %b", {REQ_READY_1, REQ_READY_0}, 2'b01 << win); end
    n_vec++; if ({PSEL, PENABLE} !== 2'b00) begin n_err++; $display("FAIL idle_ctl: got %b want 00", {PSEL, PENABLE}); end
    m_last = (win == 1);
    tick;
    // The loser keeps requesting; it must not be accepted while the bus is busy.
    if (win == 0) REQ_VALID_0 = 0; else REQ_VALID_1 = 0;
    #1;
    n_vec++; if ({PSEL, PENABLE} !== 2'b10) begin n_err++; $display("FAIL setup_ctl: got %b want 10", {PSEL, PENABLE}); end
    n_vec++; if ({PWRITE, PADDR, PWDATA} !== {wr[win], a[win], d[win]}) begin n_err++; $display("FAIL setup_bus: got %b %h %h want %b %h %h", PWRITE, PADDR, PWDATA, wr[win], a[win], d[win]); end
    n_vec++; if ({REQ_READY_1, REQ_READY_0} !== 2'b00) begin n_err++; $display("FAIL busy_ready: got %b want 00", {REQ_READY_1, REQ_READY_0}); end
    tmo = (TO > 0) && (w >= TO);
    acc = tmo ? TO : w + 1;
    for (int i = 0; i < acc; i++) begin
      tick;
      PREADY  = (!tmo && i == w);
      PSLVERR = PREADY ? serr : 1'($urandom);
      PRDATA  = PREADY ? rd : $urandom;
      #1;
      n_vec++; if ({PSEL, PENABLE, REQ_READY_1, REQ_READY_0} !== 4'b1100) begin n_err++; $display("FAIL access_ctl cyc%0d: got %b want 1100", i, {PSEL, PENABLE, REQ_READY_1, REQ_READY_0}); end
      n_vec++; if ({PWRITE, PADDR, PWDATA} !== {wr[win], a[win], d[win]}) begin n_err++; $display("FAIL access_bus cyc%0d: got %h %h want %h %h", i, PADDR, PWDATA, a[win], d[win]); end
      n_vec++; if ({RSP_VALID_1, RSP_VALID_0} !== 2'b00) begin n_err++; $display("FAIL early_rsp cyc%0d: got %b", i, {RSP_VALID_1, RSP_VALID_0}); end
    end
    tick;
    PREADY = 0; PSLVERR = 0; REQ_VALID_0 = 0; REQ_VALID_1 = 0;
    pend       = win;
    pend_err   = tmo ? 1'b1 : serr;
    pend_rdata = (tmo || wr[win]) ? '0 : rd;
  endtask

  task automatic test_drain;
    logic [DW-1:0] got;
    REQ_VALID_0 = 0; REQ_VALID_1 = 0;
    #1;
    if (pend >= 0) begin
      got = (pend == 1) ? RSP_RDATA_1 : RSP_RDATA_0;
      n_vec++; if ({RSP_VALID_1, RSP_VALID_0} !== (2'b01 << pend)) begin n_err++; $display("FAIL drain_valid: got %b want %b", {RSP_VALID_1, RSP_VALID_0}, 2'b01 << pend); end
      n_vec++; if (got !== pend_rdata) begin n_err++; $display("FAIL drain_rdata: got %h want %h", got, pend_rdata); end
      n_vec++; if (((pend == 1) ? RSP_ERR_1 : RSP_ERR_0) !== pend_err) begin n_err++; $display("FAIL drain_err: want %b", pend_err); end
    end
    n_vec++; if (PSEL !== 1'b0) begin n_err++; $display("FAIL drain_psel: got %b want 0", PSEL); end
    pend = -1;
    tick;
  endtask

  task automatic test_rr;
    // Fresh from reset: a held tie must be served 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (int'(m_last) != ((k % 2 == 0) ? 1 : 0)) begin n_err++; $display("FAIL rr_order xfer%0d: last=%0d", k, m_last); end
      xfer(2'b11, 2'($urandom), {10'($urandom), 10'($urandom)}, {32'($urandom), 32'($urandom)}, 0, 0, $urandom);
    end
  endtask

  task automatic test_single_read;
    xfer(2'b01, 2'b00, {10'h0, 10'h004}, {32'h0, 32'h0}, 0, 0, 32'hDEADBEEF);
  endtask

  task automatic test_wait_err;
    xfer(2'b10, 2'b10, {10'h2A5, 10'h0}, {32'hCAFEF00D, 32'h0}, 3, 1, 32'h12345678);
  endtask

  task automatic test_timeout;
    xfer(2'b01, 2'b00, {10'h0, 10'h155}, {32'h0, 32'h0}, TO, 0, 32'hFFFFFFFF);
    // PREADY rises in the very cycle the abort would fire: completion wins.
    xfer(2'b10, 2'b00, {10'h0F0, 10'h0}, {32'h0, 32'h0}, TO - 1, 0, 32'hA5A5A5A5);
  endtask

  task automatic test_mid_reset;
    test_drain;
    REQ_VALID_0 = 1; REQ_WRITE_0 = 0; REQ_ADDR_0 = 10'h3C;
    #1;
    n_vec++; if ({REQ_READY_1, REQ_READY_0} !== 2'b01) begin n_err++; $display("FAIL mr_grant: got %b want 01", {REQ_READY_1, REQ_READY_0}); end
    tick; REQ_VALID_0 = 0;
    tick; PREADY = 0;
    tick; PRESET = 1;
    tick; PRESET = 0;
    #1;
    n_vec++; if ({PSEL, PENABLE} !== 2'b00) begin n_err++; $display("FAIL mr_idle: got %b want 00", {PSEL, PENABLE}); end
    n_vec++; if ({RSP_VALID_1, RSP_VALID_0} !== 2'b00) begin n_err++; $display("FAIL mr_rsp: got %b want 00", {RSP_VALID_1, RSP_VALID_0}); end
    m_last = 1'b1;
    pend = -1;
    // Port 0 was served last, but reset restores the initial priority.
    xfer(2'b11, 2'b01, {10'h111, 10'h222}, {32'h11111111, 32'h22222222}, 1, 0, 32'h0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      int w;
      w = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
      xfer(2'($urandom_range(1, 3)), 2'($urandom), {10'($urandom), 10'($urandom)},
           {32'($urandom), 32'($urandom)}, w, 1'($urandom), $urandom);
    end
  endtask

  initial begin
    test_reset;
    test_rr;
    test_single_read;
    test_wait_err;
    test_timeout;
    test_mid_reset;
    test_random;
    test_drain;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
